// File: rtl/mul_pkg.sv
// Shared widths and output-FSM encoding for the repeated-addition multiplier datapath.
package mul_pkg;

  localparam int MUL_W  = 16;
  localparam int MUL_PW = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    SPENT = 2'd2
  } out_state_e;

endpackage

// File: rtl/mul_if.sv
// Controller strobes, operand bus and result valid/ready handshake of the multiplier datapath.
interface mul_if
  import mul_pkg::*;
#(
  parameter int W  = MUL_W,
  parameter int PW = MUL_PW
) ();

  logic [W-1:0]  datain;
  logic          lda;
  logic          ldb;
  logic          ldp;
  logic          clrp;
  logic          decb;
  logic          done;
  logic          eqz;
  logic [PW-1:0] res_data;
  logic          res_valid;
  logic          res_ready;
  logic          ovf;

  modport master (
    output datain, lda, ldb, ldp, clrp, decb, done, res_ready,
    input  eqz, res_data, res_valid, ovf
  );

  modport slave (
    input  datain, lda, ldb, ldp, clrp, decb, done, res_ready,
    output eqz, res_data, res_valid, ovf
  );

endinterface

// File: rtl/mul_result_buf.sv
// Captures the product on the rising edge of done and holds it under valid/ready until accepted;
// a done level held high yields exactly one result.
module mul_result_buf
  import mul_pkg::*;
#(
  parameter int PW = MUL_PW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_done,
  input  logic [PW-1:0] i_p,
  input  logic          i_ready,
  output logic [PW-1:0] o_data,
  output logic          o_valid
);

  out_state_e    r_state;
  out_state_e    w_state_nxt;
  logic          r_done_d;
  logic [PW-1:0] r_data;
  logic [PW-1:0] w_data_nxt;
  logic          r_valid;
  logic          w_valid_nxt;

  // State, done history and result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_done_d <= 1'b0;
      r_data   <= {PW{1'b0}};
      r_valid  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_done_d <= i_done;
      r_data   <= w_data_nxt;
      r_valid  <= w_valid_nxt;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    w_state_nxt = r_state;
    w_data_nxt  = r_data;
    w_valid_nxt = r_valid;
    case (r_state)
      IDLE: begin
        if (i_done && !r_done_d) begin
          w_state_nxt = HOLD;
          w_data_nxt  = i_p;
          w_valid_nxt = 1'b1;
        end else begin
          w_state_nxt = IDLE;
          w_valid_nxt = 1'b0;
        end
      end
      HOLD: begin
        if (i_ready) begin
          w_state_nxt = SPENT;
          w_valid_nxt = 1'b0;
        end else begin
          w_state_nxt = HOLD;
          w_valid_nxt = 1'b1;
        end
      end
      SPENT: begin
        // Wait for done to drop so a re-armed controller gets a fresh edge.
        if (!i_done) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = SPENT;
        end
        w_valid_nxt = 1'b0;
      end
      default: begin
        w_state_nxt = IDLE;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;

endmodule

// File: rtl/mul_datapath.sv
// Repeated-addition multiplier datapath: operand A, down-counter B, accumulator P and result buffer.
// Optional sticky accumulator overflow flag enabled by defining MUL_OVF_DETECT_EN.
module mul_datapath
  import mul_pkg::*;
#(
  parameter int W  = MUL_W,
  parameter int PW = MUL_PW
) (
  input logic clk,
  input logic rst_n,
  mul_if.slave bus
);

  localparam logic [W-1:0] ONE_W = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [PW-1:0] r_p;
  logic [PW-1:0] w_a_ext;
  logic [PW-1:0] w_p_nxt;
  logic          w_eqz;
  logic          w_acc_en;

  assign w_eqz    = (r_b == {W{1'b0}});
  assign w_acc_en = bus.ldp & ~w_eqz;
  assign w_a_ext  = PW'(r_a);
  assign bus.eqz  = w_eqz;

  // Operand A.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a <= {W{1'b0}};
    end else if (bus.lda) begin
      r_a <= bus.datain;
    end
  end

  // Down-counter B; load beats decrement and the zero guard stops any wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_b <= {W{1'b0}};
    end else if (bus.ldb) begin
      r_b <= bus.datain;
    end else if (bus.decb && !w_eqz) begin
      r_b <= r_b - ONE_W;
    end
  end

  // Accumulator P; clear beats accumulate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p <= {PW{1'b0}};
    end else if (bus.clrp) begin
      r_p <= {PW{1'b0}};
    end else if (w_acc_en) begin
      r_p <= w_p_nxt;
    end
  end

`ifdef MUL_OVF_DETECT_EN
  logic [PW:0] w_sum;
  logic        r_ovf;

  assign w_sum   = {1'b0, r_p} + {1'b0, w_a_ext};
  assign w_p_nxt = w_sum[PW-1:0];
  assign bus.ovf = r_ovf;

  // Sticky carry-out flag, cleared together with P.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (bus.clrp) begin
      r_ovf <= 1'b0;
    end else if (w_acc_en && w_sum[PW]) begin
      r_ovf <= 1'b1;
    end
  end
`else
  assign w_p_nxt = r_p + w_a_ext;
  assign bus.ovf = 1'b0;
`endif

  mul_result_buf #(
    .PW(PW)
  ) u_result_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_done  (bus.done),
    .i_p     (r_p),
    .i_ready (bus.res_ready),
    .o_data  (bus.res_data),
    .o_valid (bus.res_valid)
  );

endmodule
